matrix_adder: RTL and testbench
===============================

MATRIX_ADDER -- requirements
Module: matrix_adder

Interface
REQ-001 Parameter DIM, default 5, matrix dimension (DIM x DIM elements).
REQ-002 Parameter W, default 8, element width in bits, signed two's complement.
REQ-003 Parameter SATURATE, default 0. 0 = wrap-around sums; 1 = clamp to signed range.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  operand-valid strobe, sampled on the rising clk edge.
REQ-008 matrix_A  input  DIM*DIM*W (200)  operand A, packed.
REQ-009 matrix_B  input  DIM*DIM*W (200)  operand B, packed.
REQ-010 result_out  output  DIM*DIM*W (200)  registered A+B, packed.
REQ-011 overflow_map  output  DIM*DIM (25)  per-element overflow flags; bit k belongs to element k.
REQ-012 overflow  output  1  OR of all overflow_map bits.
REQ-013 done  output  1  one-cycle pulse: result_out/overflow valid.

Function
REQ-014 Packing: element (row i, col j), i,j in 0..DIM-1, SHALL occupy bits [(i*DIM+j)*W +: W]; k = i*DIM+j; element 0 is the LSBs.
REQ-015 For each k: sum_k = A_k + B_k, both operands interpreted as signed W-bit values.
REQ-016 overflow_map[k] SHALL be 1 iff A_k and B_k have equal sign bits and the W-bit wrapped sum has a different sign bit.
REQ-017 SATURATE=0: result element = low W bits of the sum (wrap-around).
REQ-018 SATURATE=1, overflow_map[k] set: result element = +(2^(W-1)-1) for positive operands, -(2^(W-1)) for negative operands. Otherwise it is the exact sum.
REQ-019 On a rising edge with start=1, result_out, overflow_map and overflow SHALL load the values computed from the current matrix_A/matrix_B. Latency: exactly 1 cycle.
REQ-020 done SHALL be 1 in the cycle following each start edge and 0 otherwise.
REQ-021 Back-to-back start (every cycle) SHALL be accepted. Each accepted start gives one done and a fresh result; there is no busy state.
REQ-022 With start=0, result_out, overflow_map and overflow SHALL hold their last values. Operand changes without start SHALL have no effect.
REQ-023 All elements SHALL compute in parallel in the same cycle. There is no cross-element carry.

Reset
REQ-024 While rst_n=0, asynchronously and independent of clk: result_out=0, overflow_map=0, overflow=0, done=0.
REQ-025 A start in flight when rst_n falls SHALL be discarded: no done pulse, outputs remain 0.
REQ-026 The first start edge after rst_n rises SHALL behave normally.

Verification
REQ-027 Ascending matrices. A=B with elements k=0..24 = {14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,1,2,...,10} (element 0 = 14, element 24 = 10), one start. Required response:
- done=1 one cycle later
- result element 0 = 28, element 24 = 20, element 14 = 0
- overflow=0, overflow_map=0
REQ-028 Positive overflow, SATURATE=0. A_0=127, B_0=1, all other elements 0, start. Required response:
- result element 0 = -128 (8'h80), all others 0
- overflow_map=25'h0000001, overflow=1
REQ-029 Negative overflow at the top element. A_24=-128, B_24=-1, start. Required response:
- SATURATE=0: element 24 = 127, overflow_map bit 24 = 1, overflow=1
- SATURATE=1: element 24 = -128, flags the same
REQ-030 Mixed signs, no overflow. A_k=-100, B_k=100 for all k, then A_k=-64, B_k=-64. Required response:
- first start: all elements 0, overflow=0
- second start: all elements -128, overflow=0 (boundary, not overflow)
- SATURATE=1, 127+127: element = 127
REQ-031 Handshake and hold:
- start on 3 consecutive cycles with different operands: 3 done pulses, results in order
- then start=0 with changing operands: outputs hold
REQ-032 Reset mid-operation. Assert rst_n=0 asynchronously between edges after a start, before done. Required response:
- outputs clear immediately, no done pulse
- after release, a new start produces a correct result

Source files
------------

// File: rtl/matrix_adder.sv
// Element-wise signed addition of two packed DIM x DIM matrices with
// optional saturation, a one-cycle registered result and per-element overflow flags.
module matrix_adder #(
    parameter int DIM      = 5,
    parameter int W        = 8,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIM*DIM*W-1:0] matrix_A,
    input  logic [DIM*DIM*W-1:0] matrix_B,
    output logic [DIM*DIM*W-1:0] result_out,
    output logic [DIM*DIM-1:0]   overflow_map,
    output logic                 overflow,
    output logic                 done
);

    localparam int N = DIM * DIM;

    // Clamp to the signed range only when saturation is enabled; the sign of
    // the (equal-signed) operands tells which rail was crossed.
    function automatic logic [W-1:0] saturate(input logic signed [W-1:0] sum,
                                              input logic ovf,
                                              input logic neg);
        if ((SATURATE != 0) && ovf)
            return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return sum;
    endfunction

    logic [N*W-1:0] res_p0;
    logic [N-1:0]   ovf_p0;

    // Stage p0: combinational per-element add, no carry between elements
    for (genvar k = 0; k < N; k++) begin : g_elem
        logic signed [W-1:0] a_k;
        logic signed [W-1:0] b_k;
        logic signed [W-1:0] sum_k;

        assign a_k   = matrix_A[k*W +: W];
        assign b_k   = matrix_B[k*W +: W];
        assign sum_k = a_k + b_k;

        assign ovf_p0[k]        = (a_k[W-1] == b_k[W-1]) && (sum_k[W-1] != a_k[W-1]);
        assign res_p0[k*W +: W] = saturate(sum_k, ovf_p0[k], a_k[W-1]);
    end

    logic [N*W-1:0] res_p1;
    logic [N-1:0]   ovf_map_p1;
    logic           ovf_p1;
    logic           vld_p1;

    // Stage p1: results load only on start and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1     <= '0;
            ovf_map_p1 <= '0;
            ovf_p1     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= start;
            if (start) begin
                res_p1     <= res_p0;
                ovf_map_p1 <= ovf_p0;
                ovf_p1     <= |ovf_p0;
            end
        end
    end

    assign result_out   = res_p1;
    assign overflow_map = ovf_map_p1;
    assign overflow     = ovf_p1;
    assign done         = vld_p1;

endmodule

// File: tb/tb_matrix_adder.sv
// Directed bench for matrix_adder: wrap-around and saturating instances share
// stimulus; a scoreboard queue per instance holds expected results per start.
module tb_matrix_adder;

    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int N   = DIM * DIM;
    localparam int RW  = N*W + N + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N*W-1:0] matrix_A;
    logic [N*W-1:0] matrix_B;

    logic [N*W-1:0] res_w, res_s;
    logic [N-1:0]   map_w, map_s;
    logic           ovf_w, ovf_s, done_w, done_s;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] qw[$];
    logic [RW-1:0] qs[$];
    logic [RW-1:0] cur_w, cur_s;

    always #5 clk = ~clk;

    matrix_adder #(.DIM(DIM), .W(W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start),
        .matrix_A(matrix_A), .matrix_B(matrix_B),
        .result_out(res_w), .overflow_map(map_w), .overflow(ovf_w), .done(done_w)
    );

    matrix_adder #(.DIM(DIM), .W(W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .matrix_A(matrix_A), .matrix_B(matrix_B),
        .result_out(res_s), .overflow_map(map_s), .overflow(ovf_s), .done(done_s)
    );

    // Reference: exact integer sum, range test for overflow, clamp or wrap.
    function automatic logic [RW-1:0] model(input logic [N*W-1:0] a,
                                            input logic [N*W-1:0] b,
                                            input bit sat);
        logic [N*W-1:0] res;
        logic [N-1:0]   map;
        for (int k = 0; k < N; k++) begin
            logic signed [W-1:0] ea, eb;
            int s, r;
            ea = a[k*W +: W];
            eb = b[k*W +: W];
            s  = int'(ea) + int'(eb);
            map[k] = (s > 127) || (s < -128);
            r = s;
            if (sat && map[k]) r = (s > 0) ? 127 : -128;
            res[k*W +: W] = r[W-1:0];
        end
        return {|map, map, res};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, " wrap result"},  RW'(res_w), RW'(cur_w[N*W-1:0]));
        chk({tag, " wrap map"},     RW'(map_w), RW'(cur_w[N*W +: N]));
        chk({tag, " wrap overflow"}, RW'(ovf_w), RW'(cur_w[RW-1]));
        chk({tag, " sat result"},   RW'(res_s), RW'(cur_s[N*W-1:0]));
        chk({tag, " sat map"},      RW'(map_s), RW'(cur_s[N*W +: N]));
        chk({tag, " sat overflow"}, RW'(ovf_s), RW'(cur_s[RW-1]));
    endtask

    // One clock: drive start, expect done exactly when start was sampled.
    task automatic step(input string tag, input bit st);
        start = st;
        if (st) begin
            qw.push_back(model(matrix_A, matrix_B, 1'b0));
            qs.push_back(model(matrix_A, matrix_B, 1'b1));
        end
        @(posedge clk);
        #1;
        chk({tag, " done wrap"}, RW'(done_w), RW'(st));
        chk({tag, " done sat"},  RW'(done_s), RW'(st));
        if (st) begin
            if (qw.size() > 0) cur_w = qw.pop_front();
            if (qs.size() > 0) cur_s = qs.pop_front();
        end
        chk_outputs(tag);
        start = 1'b0;
    endtask

    task automatic flush_model();
        qw.delete();
        qs.delete();
        cur_w = '0;
        cur_s = '0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " wrap cleared"}, RW'({done_w, ovf_w, map_w, res_w}), '0);
        chk({tag, " sat cleared"},  RW'({done_s, ovf_s, map_s, res_s}), '0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        matrix_A = '0;
        matrix_B = '0;
        flush_model();

        #2;
        chk_cleared("reset async");
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset held");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ascending matrices
        for (int k = 0; k < N; k++) begin
            matrix_A[k*W +: W] = (k <= 14) ? W'(14 - k) : W'(k - 14);
        end
        matrix_B = matrix_A;
        step("ascending", 1'b1);
        chk("asc elem0",  RW'(res_w[0 +: W]),    RW'(8'd28));
        chk("asc elem24", RW'(res_w[24*W +: W]), RW'(8'd20));
        chk("asc elem14", RW'(res_w[14*W +: W]), RW'(8'd0));
        chk("asc ovf",    RW'({ovf_w, map_w}),   '0);

        // Positive overflow on element 0
        matrix_A = '0; matrix_B = '0;
        matrix_A[0 +: W] = 8'd127;
        matrix_B[0 +: W] = 8'd1;
        step("pos overflow", 1'b1);
        chk("pos wrap elem0", RW'(res_w), RW'(8'h80));
        chk("pos wrap map",   RW'(map_w), RW'(25'h0000001));
        chk("pos wrap ovf",   RW'(ovf_w), RW'(1'b1));
        chk("pos sat elem0",  RW'(res_s), RW'(8'h7F));

        // Negative overflow on the top element
        matrix_A = '0; matrix_B = '0;
        matrix_A[24*W +: W] = 8'h80;
        matrix_B[24*W +: W] = 8'hFF;
        step("neg overflow", 1'b1);
        chk("neg wrap elem24", RW'(res_w[24*W +: W]), RW'(8'h7F));
        chk("neg sat elem24",  RW'(res_s[24*W +: W]), RW'(8'h80));
        chk("neg map",         RW'({ovf_s, map_s, ovf_w, map_w}),
            RW'({1'b1, 25'h1000000, 1'b1, 25'h1000000}));

        // Mixed signs, then the exact negative boundary, then 127+127
        for (int k = 0; k < N; k++) begin
            matrix_A[k*W +: W] = 8'h9C;
            matrix_B[k*W +: W] = 8'h64;
        end
        step("mixed", 1'b1);
        chk("mixed zero", RW'({ovf_w, res_w}), '0);
        for (int k = 0; k < N; k++) begin
            matrix_A[k*W +: W] = 8'hC0;
            matrix_B[k*W +: W] = 8'hC0;
        end
        step("boundary", 1'b1);
        chk("boundary elem7", RW'({ovf_w, res_w[7*W +: W]}), RW'({1'b0, 8'h80}));
        for (int k = 0; k < N; k++) begin
            matrix_A[k*W +: W] = 8'h7F;
            matrix_B[k*W +: W] = 8'h7F;
        end
        step("max pos", 1'b1);
        chk("max sat elem3",  RW'(res_s[3*W +: W]), RW'(8'h7F));
        chk("max wrap elem3", RW'(res_w[3*W +: W]), RW'(8'hFE));

        // Back-to-back starts, then hold with changing operands
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < N; k++) begin
                matrix_A[k*W +: W] = W'($urandom_range(255));
                matrix_B[k*W +: W] = W'($urandom_range(255));
            end
            step($sformatf("b2b %0d", n), 1'b1);
        end
        for (int n = 0; n < 3; n++) begin
            matrix_A = {N{W'($urandom_range(255))}};
            matrix_B = {N{W'($urandom_range(255))}};
            step($sformatf("hold %0d", n), 1'b0);
        end

        // Reset after a start edge: done and data clear immediately
        matrix_A = {N{8'h11}};
        matrix_B = {N{8'h22}};
        step("pre reset", 1'b1);
        #3 rst_n = 1'b0;
        #1;
        flush_model();
        chk_cleared("reset after edge");

        // Start in flight when reset falls is discarded
        @(posedge clk);
        #2 rst_n = 1'b1;
        start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("reset in flight");
        @(posedge clk);
        #1;
        chk_cleared("in flight no done");
        start = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_cleared("idle after release");

        // First start after release behaves normally
        for (int k = 0; k < N; k++) begin
            matrix_A[k*W +: W] = W'(k * 9);
            matrix_B[k*W +: W] = W'(k * 3 + 100);
        end
        step("post reset", 1'b1);
        step("post reset idle", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
